convolutor: RTL and testbench

Streaming 3x3 2-D convolution engine for raster-ordered pixel streams; sits between a pixel source (camera/frame reader) and downstream feature logic.
- Holds the last two image rows in internal line buffers and a 9-entry programmable signed kernel.
- Emits one full-precision signed result per fully-covered 3x3 window (valid-only, no padding).

---
 rtl/convolutor.sv | 149 ++++++++++++++
 tb/tb_convolutor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/convolutor.sv
// Streaming 3x3 convolution (correlation) over raster pixels, valid windows only.
// Optional build macro RELU_EN clamps negative results to zero.
module convolutor #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CW    = 8,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       pix_in,
    input  logic                pix_valid,
    input  logic                sof,
    input  logic                coef_we,
    input  logic [3:0]          coef_addr,
    input  logic [CW-1:0]       coef_data,
    output logic [DW+CW+4:0]    out_data,
    output logic                out_valid,
    output logic                out_last
);

    localparam int unsigned AW = DW + CW + 5;
    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [XW-1:0]        x, xe;
    logic [YW-1:0]        y, ye;
    logic                 x_end, y_end;

    logic [DW-1:0]        lb0 [IMG_W];
    logic [DW-1:0]        lb1 [IMG_W];
    logic [DW-1:0]        col [3];
    logic [DW-1:0]        w   [9];

    logic                 cw_q;
    logic [3:0]           ca_q;
    logic [CW-1:0]        cd_q;
    logic signed [CW-1:0] k   [9];

    logic signed [AW-1:0] p   [9];
    logic                 v0, l0, v1, l1;
    logic signed [AW-1:0] sum_c, res_c;

    // Effective position of the incoming pixel; sof forces (0,0).
    always_comb begin
        xe    = sof ? '0 : x;
        ye    = sof ? '0 : y;
        x_end = (xe == XW'(IMG_W - 1));
        y_end = (ye == YW'(IMG_H - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_valid) begin
            x <= x_end ? '0 : xe + XW'(1);
            if (x_end) y <= y_end ? '0 : ye + YW'(1);
            else       y <= ye;
        end
    end

    // lb1 holds row y-1 and lb0 row y-2 at each column; contents need no reset.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb0[xe] <= lb1[xe];
            lb1[xe] <= pix_in;
        end
    end

    always_comb begin
        col[0] = lb0[xe];
        col[1] = lb1[xe];
        col[2] = pix_in;
    end

    // 3x3 window shift register, index r*3+c with c=2 the newest column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) w[i] <= '0;
            v0 <= 1'b0;
            l0 <= 1'b0;
        end else begin
            if (pix_valid) begin
                for (int r = 0; r < 3; r++) begin
                    w[r*3]   <= w[r*3+1];
                    w[r*3+1] <= w[r*3+2];
                    w[r*3+2] <= col[r];
                end
            end
            v0 <= pix_valid && (xe >= XW'(2)) && (ye >= YW'(2));
            l0 <= pix_valid && x_end && y_end;
        end
    end

    // Writes are staged one cycle so a window captured on the write edge
    // still multiplies with the previous coefficient.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cw_q <= 1'b0;
            ca_q <= '0;
            cd_q <= '0;
            for (int i = 0; i < 9; i++) k[i] <= '0;
        end else begin
            cw_q <= coef_we;
            ca_q <= coef_addr;
            cd_q <= coef_data;
            if (cw_q && (ca_q <= 4'd8)) k[ca_q] <= $signed(cd_q);
        end
    end

    // Stage 1: products of zero-extended pixels and signed coefficients.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) p[i] <= '0;
            v1 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++)
                p[i] <= AW'($signed({1'b0, w[i]})) * AW'(k[i]);
            v1 <= v0;
            l1 <= v0 && l0;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++) sum_c = sum_c + p[i];
`ifdef RELU_EN
        res_c = sum_c[AW-1] ? '0 : sum_c;
`else
        res_c = sum_c;
`endif
    end

    // Stage 2: registered result; data holds between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= v1;
            out_last  <= v1 && l1;
            if (v1) out_data <= res_c;
        end
    end

endmodule

// File: tb/tb_convolutor.sv
// Randomized and directed bench for convolutor against a frame-array reference model.
module tb_convolutor;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = DW + CW + 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          sof;
    logic          coef_we;
    logic [3:0]    coef_addr;
    logic [CW-1:0] coef_data;
    logic [AW-1:0] out_data;
    logic          out_valid;
    logic          out_last;

    convolutor #(.DW(DW), .CW(CW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct { int due; longint val; bit last; } exp_t;

    exp_t   q[$];
    longint obs[$];
    longint last_val;
    int     img [H][W];
    int     kc  [9];
    int     mx, my, cyc;
    longint held;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic signed [63:0] o, input logic signed [63:0] e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 9; i++) kc[i] = 0;
        mx = 0; my = 0; held = 0;
    endtask

    // Reference: store the frame by position and evaluate each window directly.
    task automatic model_edge(input bit pv, input int px, input bit sf, input bit we, input int addr, input int data);
        longint s;
        exp_t   e;
        if (pv) begin
            if (sf) begin mx = 0; my = 0; end
            img[my][mx] = px;
            if (mx >= 2 && my >= 2) begin
                s = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        s += longint'(kc[r*3+c]) * longint'(img[my-2+r][mx-2+c]);
`ifdef RELU_EN
                if (s < 0) s = 0;
`endif
                e.due = cyc + 2; e.val = s; e.last = (mx == W-1 && my == H-1);
                q.push_back(e);
            end
            if (mx == W-1) begin
                mx = 0;
                my = (my == H-1) ? 0 : my + 1;
            end else mx++;
        end
        if (we && addr < 9) kc[addr] = data;
    endtask

    task automatic compare();
        bit ev;
        if (!rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_data", $signed(out_data), 0);
            check("rst_last", out_last, 0);
        end else begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            check("out_valid", out_valid, ev);
            if (ev) begin
                check("out_data", $signed(out_data), q[0].val);
                check("out_last", out_last, q[0].last);
                held = q[0].val;
                obs.push_back($signed(out_data));
                if (out_last) last_val = $signed(out_data);
                void'(q.pop_front());
            end else begin
                if (q.size() > 0 && q[0].due < cyc) begin
                    check("missed_result", q[0].due, cyc);
                    void'(q.pop_front());
                end
                check("hold_data", $signed(out_data), held);
                check("idle_last", out_last, 0);
            end
        end
    endtask

    task automatic step(input bit pv, input int px, input bit sf,
                        input bit we = 1'b0, input int addr = 0, input int data = 0);
        pix_valid = pv; pix_in = DW'(px); sof = sf;
        coef_we = we; coef_addr = 4'(addr); coef_data = CW'(data);
        @(posedge clk);
        cyc++;
        if (rst) model_edge(pv, px, sf, we, addr, data);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic wr(input int addr, input int data);
        step(0, 0, 0, 1'b1, addr, data);
    endtask

    task automatic kernel_fill(input int center, input int others);
        for (int i = 0; i < 9; i++) wr(i, (i == 4) ? center : others);
    endtask

    task automatic id_frame(input bit toggle);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                if (toggle) step(0, $urandom_range(0, 255), $urandom_range(0, 1));
                step(1, xx + 10*yy, (xx == 0 && yy == 0));
            end
    endtask

    task automatic id_results(input string tag);
        int idv [6] = '{11, 12, 13, 21, 22, 23};
        check({tag, "_count"}, obs.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < obs.size()) check({tag, "_val"}, obs[i], idv[i]);
        check({tag, "_lastval"}, last_val, 23);
    endtask

    initial begin
        cyc = 0; last_val = -1;
        model_reset();
        rst = 1'b0;
        // Reset held with random inputs.
        for (int i = 0; i < 6; i++)
            step($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
        rst = 1'b1;

        // No coefficient writes: every result must be zero.
        obs.delete();
        for (int i = 0; i < W*H; i++) step(1, $urandom_range(0, 255), i == 0);
        idle(4);
        check("zero_count", obs.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < obs.size()) check("zero_val", obs[i], 0);

        // Identity kernel, continuous frame.
        wr(4, 1);
        obs.delete(); last_val = -1;
        id_frame(1'b0);
        idle(4);
        id_results("ident");

        // Identity kernel, valid toggling.
        obs.delete(); last_val = -1;
        id_frame(1'b1);
        idle(4);
        id_results("toggle");

        // sof reasserted at (3,2).
        obs.delete();
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < W; xx++)
                if (yy < 2 || xx < 3) step(1, xx + 10*yy, (xx == 0 && yy == 0));
        for (int i = 0; i < W*H; i++) step(1, (i % W) + 10*(i / W), i == 0);
        idle(4);
        check("sof_count", obs.size(), 7);

        // Box kernel with saturated pixels, then a single negative tap.
        kernel_fill(1, 1);
        obs.delete();
        for (int i = 0; i < W*H; i++) step(1, 255, i == 0);
        idle(4);
        if (obs.size() > 0) check("box_val", obs[0], 2295);
        else check("box_count", 0, 6);
        kernel_fill(0, 0);
        wr(0, -128);
        obs.delete();
        for (int i = 0; i < W*H; i++) step(1, 255, i == 0);
        idle(4);
`ifdef RELU_EN
        if (obs.size() > 0) check("neg_val", obs[0], 0);
`else
        if (obs.size() > 0) check("neg_val", obs[0], -32640);
`endif
        else check("neg_count", 0, 6);

        // Random traffic with coefficient writes, stray addresses and sof.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 255),
                 (i == 0) || ($urandom_range(0, 99) < 3),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 15),
                 int'($urandom_range(0, 255)) - 128);
        idle(4);

        // Async reset between edges while a result is on the output.
        kernel_fill(1, 0);
        obs.delete();
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < W; xx++) step(1, xx + 10*yy, (xx == 0 && yy == 0));
        check("pre_async_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_data", $signed(out_data), 0);
        model_reset();
        idle(2);
        rst = 1'b1;
        wr(4, 1);
        obs.delete();
        for (int i = 0; i < 3*W; i++) step(1, 100 + i, 1'b0);
        idle(4);
        check("post_rst_count", obs.size(), 3);
        if (obs.size() == 3) check("post_rst_first", obs[0], 100 + W + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
